fifo_pop_ctrl: RTL
==================

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port wr_push, input, 1: write-side push strobe, one byte written this cycle.
REQ-004 SHALL have port wr_sel, input, 4: channel of that write.
REQ-005 SHALL have port pop_req, input, 1: consumer requests one byte.
REQ-006 SHALL have port pop_sel, input, 4: channel to pop.
REQ-007 SHALL have port flush, input, 1: discard all contents of channel flush_sel.
REQ-008 SHALL have port flush_sel, input, 4: channel to flush.
REQ-009 SHALL have port ram_dout, input, 8: shared 2-port RAM read data, valid one cycle after ram_re.
REQ-010 SHALL have port ram_re, output, 1: RAM read enable.
REQ-011 SHALL have port ram_raddr, output, 11: RAM read address.
REQ-012 SHALL have port pop_ack, output, 1: pop accepted this cycle.
REQ-013 SHALL have port dout, output, 8: popped byte.
REQ-014 SHALL have port dout_valid, output, 1: dout valid this cycle.
REQ-015 SHALL have ports empty and full, output, 11 each: per-channel status, bit n = channel n.
REQ-016 SHALL have port ovf, output, 11: sticky per-channel overflow.

Function
REQ-017 Channel map SHALL be: sel 0..9 -> channel 0..9; sel 10..15 -> channel 10 (wr_sel, pop_sel, flush_sel alike).
REQ-018 Regions (base..last, depth) SHALL be: 0..16 (17), 64..97 (34), 128..178 (51), 256..323 (68), 384..468 (85), 512..613 (102), 640..758 (119), 768..903 (136), 1024..1176 (153), 1280..1449 (170), 1536..1722 (187).
REQ-019 Each channel SHALL hold an 11-bit read pointer and an 8-bit occupancy count.
REQ-020 pop_ack SHALL equal pop_req AND NOT empty[ch(pop_sel)] AND NOT (flush AND same channel), combinationally.
REQ-021 In an ack cycle, ram_re SHALL be 1 and ram_raddr SHALL be the current pointer of that channel; otherwise ram_re = 0, ram_raddr = 0.
REQ-022 On ack, pointer SHALL increment; at last it SHALL wrap to base.
REQ-023 Byte SHALL appear on dout with dout_valid = 1 exactly two cycles after pop_ack (ram_dout registered once); dout holds its last value otherwise.
REQ-024 Count: push only +1; pop only -1; push and pop same channel same cycle -> unchanged; push and pop different channels -> each updated.
REQ-025 Push to full channel SHALL leave count at depth and set ovf[ch]; ovf clears only on reset or flush of that channel.
REQ-026 empty[n] SHALL be count==0; full[n] SHALL be count==depth[n]; both from registered counts.
REQ-027 Flush SHALL next cycle set count to 0, pointer to base, and clear ovf of that channel; a same-cycle push to it is discarded; pops already acked still deliver dout.
REQ-028 pop_req on an empty channel SHALL not ack, not move state, and be retried by the consumer.

Reset
REQ-029 On reset_n low, immediately: pointers = base, counts = 0, empty = all 1s, full = 0, ovf = 0, dout = 0, dout_valid = 0, pipeline valid bits cleared.
REQ-030 Reset mid-read SHALL drop in-flight bytes; no dout_valid until a new ack.

Structure
REQ-031 Package fifo_region_pkg SHALL hold NUM_CH = 11, per-channel BASE, LAST, DEPTH tables, and the sel-to-channel mapping function.
REQ-032 Sub-module fifo_rd_chan (pointer, count, ovf, wrap for one channel) SHALL be instantiated NUM_CH times; top holds arbitration, mux and read pipeline.

Verification
REQ-033 Reset, 3 pushes to sel 1, 3 pops sel 1 -> ram_raddr 64, 65, 66; dout_valid 2 cycles after each ack; empty[1] = 1 after.
REQ-034 17 pushes sel 0, 17 pops -> full[0] = 1 after 17th push; 17th pop at address 16; next pop wraps to 0 after refill.
REQ-035 Push and pop sel 12 same cycle with count 5 -> count stays 5, channel 10 used, pointer +1.
REQ-036 18th push to channel 0 -> ovf[0] = 1, count 17; flush sel 0 -> ovf[0] = 0, empty[0] = 1, pointer 0.
REQ-037 pop_req sel 3 while empty[3] = 1 -> pop_ack = 0, ram_re = 0, no dout_valid.
REQ-038 reset_n low one cycle after an ack -> dout_valid never asserts; all outputs at reset values.

Source files
------------

// File: rtl/fifo_region_pkg.sv
// Region map shared by the per-channel read controllers and the pop arbiter.
// Eleven channels, each a fixed slice of the shared 2048-byte RAM.
package fifo_region_pkg;

  localparam int NUM_CH = 11;
  localparam int AW     = 11;
  localparam int CW     = 8;

  localparam logic [AW-1:0] BASE [NUM_CH] = '{
    11'd0,    11'd64,   11'd128,  11'd256,  11'd384,  11'd512,
    11'd640,  11'd768,  11'd1024, 11'd1280, 11'd1536
  };

  localparam logic [AW-1:0] LAST [NUM_CH] = '{
    11'd16,   11'd97,   11'd178,  11'd323,  11'd468,  11'd613,
    11'd758,  11'd903,  11'd1176, 11'd1449, 11'd1722
  };

  localparam logic [CW-1:0] DEPTH [NUM_CH] = '{
    8'd17,  8'd34,  8'd51,  8'd68,  8'd85,  8'd102,
    8'd119, 8'd136, 8'd153, 8'd170, 8'd187
  };

  // Selects above 9 all alias onto the last (largest) channel.
  function automatic logic [3:0] sel_to_ch(input logic [3:0] sel);
    return (sel > 4'd9) ? 4'd10 : sel;
  endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// Bundle of write-side strobes, consumer pop handshake, RAM read port and
// per-channel status. The controller takes the slave view; the environment
// (write side, consumer and RAM) takes the master view.
interface fifo_pop_ctrl_if;
  import fifo_region_pkg::*;

  logic              wr_push;
  logic [3:0]        wr_sel;
  logic              pop_req;
  logic [3:0]        pop_sel;
  logic              flush;
  logic [3:0]        flush_sel;
  logic [7:0]        ram_dout;
  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic              pop_ack;
  logic [7:0]        dout;
  logic              dout_valid;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output wr_push, wr_sel, pop_req, pop_sel, flush, flush_sel, ram_dout,
    input  ram_re, ram_raddr, pop_ack, dout, dout_valid, empty, full, ovf
  );

  modport slave (
    input  wr_push, wr_sel, pop_req, pop_sel, flush, flush_sel, ram_dout,
    output ram_re, ram_raddr, pop_ack, dout, dout_valid, empty, full, ovf
  );

endinterface

// File: rtl/fifo_rd_chan.sv
// Read-side bookkeeping for one channel: read pointer with wrap inside the
// channel's region, occupancy count, and sticky overflow flag.
module fifo_rd_chan
  import fifo_region_pkg::*;
#(
  parameter logic [AW-1:0] P_BASE  = 11'd0,
  parameter logic [AW-1:0] P_LAST  = 11'd16,
  parameter logic [CW-1:0] P_DEPTH = 8'd17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] ptr,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  logic [CW-1:0] count;

  // Pointer, count and overflow; flush wins and swallows any same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= P_BASE;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      ptr   <= P_BASE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop) begin
        ptr <= (ptr == P_LAST) ? P_BASE : ptr + 11'd1;
      end
      if (push && !pop) begin
        if (count == P_DEPTH) begin
          ovf <= 1'b1;
        end else begin
          count <= count + 8'd1;
        end
      end else if (pop && !push) begin
        count <= count - 8'd1;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == P_DEPTH);

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Pop controller for an 11-channel byte FIFO sharing one 2-port RAM.
// Decodes push/pop/flush per channel, grants pops combinationally, drives the
// RAM read port and registers the returned byte into a two-cycle read pipe.
module fifo_pop_ctrl
  import fifo_region_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  fifo_pop_ctrl_if.slave   bus
);

  logic [3:0]        ch_wr;
  logic [3:0]        ch_pop;
  logic [3:0]        ch_flush;
  logic [AW-1:0]     ptr [NUM_CH];
  logic [NUM_CH-1:0] push_v;
  logic [NUM_CH-1:0] pop_v;
  logic [NUM_CH-1:0] flush_v;
  logic [NUM_CH-1:0] empty_v;
  logic [NUM_CH-1:0] full_v;
  logic [NUM_CH-1:0] ovf_v;
  logic [AW-1:0]     ptr_sel;
  logic              empty_sel;
  logic              ack;
  logic              rd_v1;

  assign ch_wr    = sel_to_ch(bus.wr_sel);
  assign ch_pop   = sel_to_ch(bus.pop_sel);
  assign ch_flush = sel_to_ch(bus.flush_sel);

  // Select the addressed channel's pointer and empty flag for the pop grant.
  always_comb begin
    ptr_sel   = '0;
    empty_sel = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_pop == 4'(i)) begin
        ptr_sel   = ptr[i];
        empty_sel = empty_v[i];
      end
    end
  end

  // A flush of the same channel blocks the pop so no byte leaves a dead region.
  assign ack = bus.pop_req && !empty_sel && !(bus.flush && (ch_flush == ch_pop));

  // One-hot per-channel strobes.
  always_comb begin
    push_v  = '0;
    pop_v   = '0;
    flush_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push_v[i]  = bus.wr_push && (ch_wr == 4'(i));
      pop_v[i]   = ack && (ch_pop == 4'(i));
      flush_v[i] = bus.flush && (ch_flush == 4'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    fifo_rd_chan #(
      .P_BASE  (BASE[g]),
      .P_LAST  (LAST[g]),
      .P_DEPTH (DEPTH[g])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_v[g]),
      .pop     (pop_v[g]),
      .flush   (flush_v[g]),
      .ptr     (ptr[g]),
      .empty   (empty_v[g]),
      .full    (full_v[g]),
      .ovf     (ovf_v[g])
    );
  end

  assign bus.pop_ack   = ack;
  assign bus.ram_re    = ack;
  assign bus.ram_raddr = ack ? ptr_sel : '0;
  assign bus.empty     = empty_v;
  assign bus.full      = full_v;
  assign bus.ovf       = ovf_v;

  // Read pipe: RAM answers one cycle after the grant, captured one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1          <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      rd_v1          <= ack;
      bus.dout_valid <= rd_v1;
      if (rd_v1) begin
        bus.dout <= bus.ram_dout;
      end
    end
  end

endmodule
